// File: rtl/bus_arbiter_8x32.sv
// Eight-requester round-robin arbiter feeding a one-entry output register.
// The winner is acknowledged combinationally and its word is registered on the next edge.
module bus_arbiter_8x32 #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         req,
  input  logic [8*WIDTH-1:0] req_data,
  output logic [7:0]         ack,
  output logic [2:0]         sel,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [2:0]         out_src,
  input  logic               out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [2:0]       r_ptr;
  logic [2:0]       r_src;
  logic [WIDTH-1:0] r_data;
  logic [2:0]       w_winner;
  logic             w_found;
  logic             w_any;
  logic             w_accept;

  // Search starts at the pointer and wraps, so the last winner has lowest priority.
  always_comb begin
    w_winner = 3'd0;
    w_found  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      logic [2:0] idx;
      idx = r_ptr + 3'(k);
      if (!w_found && req[idx]) begin
        w_winner = idx;
        w_found  = 1'b1;
      end
    end
  end

  assign w_any    = |req;
  // Gating with rst_n keeps ack quiet while reset is held, whatever req does.
  assign w_accept = w_any && ((r_state == EMPTY) || out_ready) && rst_n;
  assign sel      = w_any ? w_winner : 3'd0;

  always_comb begin
    ack = 8'd0;
    if (w_accept) begin
      ack[w_winner] = 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_accept) begin
      w_state_next = FULL;
    end else if ((r_state == FULL) && out_ready) begin
      w_state_next = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_ptr   <= 3'd0;
      r_src   <= 3'd0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_ptr  <= w_winner + 3'd1;
        r_src  <= w_winner;
        r_data <= req_data[w_winner*WIDTH +: WIDTH];
      end
    end
  end

  assign out_valid = (r_state == FULL);
  assign out_data  = r_data;
  assign out_src   = r_src;

endmodule

// File: doc/bus_arbiter_8x32.md
BUS_ARBITER_8X32 -- requirements
Module: bus_arbiter_8x32

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, setting the data width of each requester word and of the output.
REQ-002 Port clk: input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-004 Port req: input, 8 bits, where req[i] high means requester i holds a valid word.
REQ-005 Port req_data: input, 8*WIDTH bits, where requester i's word is at bits [WIDTH*i+WIDTH-1 : WIDTH*i].
REQ-006 Port ack: output, 8 bits, one-hot, where ack[i] high means requester i's word is captured this cycle.
REQ-007 Port sel: output, 3 bits, the 8:1 mux select code equal to the index of the current winner.
REQ-008 Port out_valid: output, 1 bit, meaning the output register holds a word.
REQ-009 Port out_data: output, WIDTH bits, the registered selected word.
REQ-010 Port out_src: output, 3 bits, the index of the requester that supplied out_data.
REQ-011 Port out_ready: input, 1 bit, meaning the downstream side consumes out_data this cycle when out_valid is high.

Function
REQ-012 The block SHALL hold a 3-bit round-robin pointer ptr; the winner is the first index i with req[i]=1, searching ptr, ptr+1, ... mod 8.
REQ-013 The output register SHALL be a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-014 accept SHALL equal (|req) AND (state==EMPTY OR out_ready).
REQ-015 On accept, in the same cycle, the block SHALL:
- assert ack[winner] combinationally;
- at the next edge, load out_data with the winner's word, out_src with winner, ptr with (winner+1) mod 8 (7 wraps to 0), and enter FULL.
REQ-016 ack SHALL be all-zero in any cycle without accept; at most one ack bit SHALL be high.
REQ-017 FULL with out_ready=1 and no accept SHALL go to EMPTY; FULL with out_ready=1 and accept SHALL stay FULL with the new word, giving one word per cycle sustained throughput.
REQ-018 FULL with out_ready=0 SHALL hold out_data, out_src, out_valid and ptr unchanged, and ack SHALL be zero (backpressure).
REQ-019 In EMPTY with req=0, ptr SHALL be unchanged.
REQ-020 sel SHALL equal the combinational winner whenever |req=1, and SHALL equal 3'd0 when req=0, independent of accept.
REQ-021 Capture latency SHALL be one cycle: a word acked in cycle N is on out_data with out_valid=1 in cycle N+1.
REQ-022 A requester whose req stays high after ack SHALL be treated as presenting a new word; it is not granted again while another requester is pending (fairness bound: at most 7 other grants between two grants to any pending requester).
REQ-023 out_data SHALL be WIDTH bits exactly; there is no truncation or extension.

Reset
REQ-024 While rst_n=0 the block SHALL force:
- state=EMPTY, out_valid=0, out_data=0, out_src=0, ptr=0;
- ack to all-zero, regardless of req.
REQ-025 Reset asserted mid-operation SHALL discard any held word without acknowledgement side effects; the first accept after release SHALL search from index 0.

Verification
REQ-026 Reset, then req=8'b0000_0001 with word 0 = 32'hDEAD_BEEF and out_ready=1:
- ack=8'h01 and sel=0 in cycle 0;
- out_valid=1, out_data=32'hDEAD_BEEF, out_src=0 in cycle 1.
REQ-027 req=8'hFF held with out_ready=1, word i=i:
- grant order 0,1,...,7,0;
- one ack per cycle;
- out_data sequence 0..7,0 with no bubbles.
REQ-028 FULL holding 32'h1234_5678, out_ready=0 for 3 cycles with req=8'h10:
- ack=0 and out_data held for all 3 cycles;
- when out_ready=1, ack=8'h10 that cycle and the new word appears the next cycle.
REQ-029 After a grant to index 7, req=8'b1000_0010:
- grant goes to 1 (wrap-around);
- the next grant goes to 7.
REQ-030 rst_n pulsed low for 1 cycle while FULL with req=8'h04:
- out_valid=0 and ack=0 during reset;
- after release, ack=8'h04 and ptr restarts the search from 0.
